// File: rtl/sram_axi_burst_bridge_if.sv
// AXI3 bus bundle between the sram/AXI burst bridge (master) and the crossbar (slave).
interface sram_axi_burst_bridge_if #(
    parameter int unsigned ID_W = 4
);
    // read address channel
    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;
    // read data channel
    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;
    // write address channel
    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;
    // write data channel
    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;
    // write response channel
    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/sram_axi_burst_bridge.sv
// Two-port sram-like to AXI3 bridge: one inst read and one data access in flight,
// separated by AXI ID, with INCR read bursts for cache refills.
module sram_axi_burst_bridge #(
    parameter int unsigned ID_W    = 4,
    parameter int unsigned INST_ID = 0,
    parameter int unsigned DATA_ID = 1,
    parameter int unsigned LEN_W   = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    // instruction port
    input  logic                   inst_req,
    input  logic [1:0]             inst_size,
    input  logic [31:0]            inst_addr,
    input  logic [LEN_W-1:0]       inst_len,
    output logic                   inst_addr_ok,
    output logic                   inst_data_ok,
    output logic                   inst_rlast,
    output logic                   inst_err,
    output logic [31:0]            inst_rdata,
    // data port
    input  logic                   data_req,
    input  logic                   data_wr,
    input  logic [1:0]             data_size,
    input  logic [31:0]            data_addr,
    input  logic [31:0]            data_wdata,
    input  logic [LEN_W-1:0]       data_len,
    output logic                   data_addr_ok,
    output logic                   data_data_ok,
    output logic                   data_rlast,
    output logic                   data_err,
    output logic [31:0]            data_rdata,
    // AXI3 master
    sram_axi_burst_bridge_if.master axi
);

    typedef enum logic [1:0] {I_IDLE, I_AR, I_R} i_state_t;
    typedef enum logic [2:0] {D_IDLE, D_AR, D_R, D_W, D_B} d_state_t;

    localparam logic [ID_W-1:0] I_ID = ID_W'(INST_ID);
    localparam logic [ID_W-1:0] D_ID = ID_W'(DATA_ID);

    i_state_t i_state, i_state_nxt;
    d_state_t d_state, d_state_nxt;

    logic [31:0]      i_addr;
    logic [1:0]       i_size;
    logic [LEN_W-1:0] i_len;
    logic [31:0]      d_addr;
    logic [31:0]      d_wdata;
    logic [1:0]       d_size;
    logic [LEN_W-1:0] d_len;

    logic ar_locked;   // AR is presented but not yet accepted; owner frozen
    logic ar_owner;    // 1 = data port owns AR
    logic ar_sel_d;
    logic ar_hs, ar_hs_i, ar_hs_d;
    logic aw_done, w_done;
    logic aw_hs, w_hs, aw_fin, w_fin;
    logic r_inst, r_data, b_data;
    logic inst_acc, data_acc;
    logic [3:0] wstrb;

    // request acceptance
    assign inst_addr_ok = (i_state == I_IDLE);
    assign data_addr_ok = (d_state == D_IDLE);
    assign inst_acc     = inst_req && inst_addr_ok;
    assign data_acc     = data_req && data_addr_ok;

    // AR arbitration: data wins a tie, owner stays fixed until arready
    assign ar_sel_d    = ar_locked ? ar_owner : (d_state == D_AR);
    assign axi.arvalid = (i_state == I_AR) || (d_state == D_AR);
    assign ar_hs       = axi.arvalid && axi.arready;
    assign ar_hs_i     = ar_hs && !ar_sel_d;
    assign ar_hs_d     = ar_hs && ar_sel_d;

    assign axi.arid    = ar_sel_d ? D_ID : I_ID;
    assign axi.araddr  = ar_sel_d ? d_addr : i_addr;
    assign axi.arlen   = ar_sel_d ? 8'(d_len) : 8'(i_len);
    assign axi.arsize  = {1'b0, (ar_sel_d ? d_size : i_size)};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;

    // write address/data: each channel drops valid once its own handshake is done
    assign aw_hs  = axi.awvalid && axi.awready;
    assign w_hs   = axi.wvalid && axi.wready;
    assign aw_fin = aw_done || aw_hs;
    assign w_fin  = w_done || w_hs;

    assign axi.awvalid = (d_state == D_W) && !aw_done;
    assign axi.wvalid  = (d_state == D_W) && !w_done;
    assign axi.awid    = D_ID;
    assign axi.awaddr  = d_addr;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = {1'b0, d_size};
    assign axi.awburst = 2'b01;
    assign axi.awlock  = 2'b00;
    assign axi.awcache = 4'b0000;
    assign axi.awprot  = 3'b000;
    assign axi.wid     = D_ID;
    assign axi.wdata   = d_wdata;
    assign axi.wstrb   = wstrb;
    assign axi.wlast   = 1'b1;

    // byte lanes from access size and low address bits
    always_comb begin
        wstrb = 4'b1111;
        case (d_size)
            2'd0:    wstrb = 4'b0001 << d_addr[1:0];
            2'd1:    wstrb = 4'b0011 << d_addr[1:0];
            default: wstrb = 4'b1111;
        endcase
    end

    // response routing by ID; beats for a port not waiting on them are dropped
    assign axi.rready = 1'b1;
    assign axi.bready = 1'b1;
    assign r_inst = axi.rvalid && (axi.rid == I_ID) && (i_state == I_R);
    assign r_data = axi.rvalid && (axi.rid == D_ID) && (d_state == D_R);
    assign b_data = axi.bvalid && (axi.bid == D_ID) && (d_state == D_B);

    assign inst_data_ok = r_inst;
    assign inst_rlast   = r_inst && axi.rlast;
    assign inst_err     = r_inst && (axi.rresp != 2'b00);
    assign inst_rdata   = axi.rdata;

    assign data_data_ok = r_data || b_data;
    assign data_rlast   = r_data && axi.rlast;
    assign data_err     = (r_data && (axi.rresp != 2'b00)) || (b_data && (axi.bresp != 2'b00));
    assign data_rdata   = axi.rdata;

    // state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_state <= I_IDLE;
            d_state <= D_IDLE;
        end else begin
            i_state <= i_state_nxt;
            d_state <= d_state_nxt;
        end
    end

    // inst FSM next state
    always_comb begin
        i_state_nxt = i_state;
        case (i_state)
            I_IDLE:  if (inst_req) i_state_nxt = I_AR;
            I_AR:    if (ar_hs_i) i_state_nxt = I_R;
            I_R:     if (r_inst && axi.rlast) i_state_nxt = I_IDLE;
            default: i_state_nxt = I_IDLE;
        endcase
    end

    // data FSM next state
    always_comb begin
        d_state_nxt = d_state;
        case (d_state)
            D_IDLE:  if (data_req) d_state_nxt = data_wr ? D_W : D_AR;
            D_AR:    if (ar_hs_d) d_state_nxt = D_R;
            D_R:     if (r_data && axi.rlast) d_state_nxt = D_IDLE;
            D_W:     if (aw_fin && w_fin) d_state_nxt = D_B;
            D_B:     if (b_data) d_state_nxt = D_IDLE;
            default: d_state_nxt = D_IDLE;
        endcase
    end

    // AR ownership lock
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_locked <= 1'b0;
            ar_owner  <= 1'b0;
        end else begin
            ar_locked <= axi.arvalid && !axi.arready;
            if (axi.arvalid) ar_owner <= ar_sel_d;
        end
    end

    // aw/w completion tracking inside D_W
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else if ((d_state != D_W) || (aw_fin && w_fin)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
        end
    end

    // request capture
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            i_addr  <= '0;
            i_size  <= '0;
            i_len   <= '0;
            d_addr  <= '0;
            d_size  <= '0;
            d_len   <= '0;
            d_wdata <= '0;
        end else begin
            if (inst_acc) begin
                i_addr <= inst_addr;
                i_size <= inst_size;
                i_len  <= inst_len;
            end
            if (data_acc) begin
                d_addr  <= data_addr;
                d_size  <= data_size;
                d_len   <= data_len;
                d_wdata <= data_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_axi_burst_bridge.sv
// Self-checking bench for sram_axi_burst_bridge: scripted AXI slave, scoreboard on data_ok beats.
module tb_sram_axi_burst_bridge;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned INST_ID = 0;
    localparam int unsigned DATA_ID = 1;
    localparam int unsigned LEN_W   = 4;

    logic             clk;
    logic             resetn;
    logic             inst_req;
    logic [1:0]       inst_size;
    logic [31:0]      inst_addr;
    logic [LEN_W-1:0] inst_len;
    logic             inst_addr_ok, inst_data_ok, inst_rlast, inst_err;
    logic [31:0]      inst_rdata;
    logic             data_req, data_wr;
    logic [1:0]       data_size;
    logic [31:0]      data_addr, data_wdata;
    logic [LEN_W-1:0] data_len;
    logic             data_addr_ok, data_data_ok, data_rlast, data_err;
    logic [31:0]      data_rdata;

    sram_axi_burst_bridge_if #(.ID_W(ID_W)) axi ();

    sram_axi_burst_bridge #(
        .ID_W(ID_W), .INST_ID(INST_ID), .DATA_ID(DATA_ID), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr), .inst_len(inst_len),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rlast(inst_rlast),
        .inst_err(inst_err), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_len(data_len),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rlast(data_rlast),
        .data_err(data_err), .data_rdata(data_rdata),
        .axi(axi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        logic        rlast;
        logic        err;
    } beat_t;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          aw_dly;
        int          w_dly;
        logic [1:0]  bresp;
        logic [3:0]  exp_wstrb;
    } wr_vec_t;

    beat_t inst_q[$];
    beat_t data_q[$];
    beat_t mon_i, mon_d;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_inst_ok = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // drive one R beat and record what the owning port should deliver
    task automatic r_set(input logic [ID_W-1:0] id, input logic [31:0] d,
                         input logic last, input logic [1:0] resp);
        beat_t e;
        axi.rvalid = 1'b1;
        axi.rid    = id;
        axi.rdata  = d;
        axi.rlast  = last;
        axi.rresp  = resp;
        e.rdata = d; e.chk_rdata = 1'b1; e.rlast = last; e.err = (resp != 2'b00);
        if (id == ID_W'(INST_ID)) inst_q.push_back(e);
        else if (id == ID_W'(DATA_ID)) data_q.push_back(e);
    endtask

    task automatic r_clr();
        axi.rvalid = 1'b0;
        axi.rlast  = 1'b0;
        axi.rresp  = 2'b00;
    endtask

    // scoreboard: compare each delivered beat against the oldest expectation
    always @(negedge clk) begin
        if (inst_data_ok) begin
            n_inst_ok++;
            if (inst_q.size() == 0) chk("inst_data_ok spurious", 32'(inst_data_ok), 32'd0);
            else begin
                mon_i = inst_q.pop_front();
                if (mon_i.chk_rdata) chk("inst_rdata", inst_rdata, mon_i.rdata);
                chk("inst_rlast", 32'(inst_rlast), 32'(mon_i.rlast));
                chk("inst_err", 32'(inst_err), 32'(mon_i.err));
            end
        end
        if (data_data_ok) begin
            if (data_q.size() == 0) chk("data_data_ok spurious", 32'(data_data_ok), 32'd0);
            else begin
                mon_d = data_q.pop_front();
                if (mon_d.chk_rdata) chk("data_rdata", data_rdata, mon_d.rdata);
                chk("data_rlast", 32'(data_rlast), 32'(mon_d.rlast));
                chk("data_err", 32'(data_err), 32'(mon_d.err));
            end
        end
    end

    // single data write with independent awready/wready delays
    task automatic do_write(input wr_vec_t v);
        beat_t e;
        int n;
        data_req = 1'b1; data_wr = 1'b1; data_size = v.size;
        data_addr = v.addr; data_wdata = v.wdata; data_len = 4'hF;
        #1 chk("wr addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        n = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
        for (int c = 0; c <= n; c++) begin
            axi.awready = (c == v.aw_dly);
            axi.wready  = (c == v.w_dly);
            #1;
            chk("wr awvalid", 32'(axi.awvalid), 32'(c <= v.aw_dly));
            chk("wr wvalid", 32'(axi.wvalid), 32'(c <= v.w_dly));
            if (c == 0) begin
                chk("wr awaddr", axi.awaddr, v.addr);
                chk("wr wstrb", 32'(axi.wstrb), 32'(v.exp_wstrb));
                chk("wr wdata", axi.wdata, v.wdata);
                chk("wr wlast", 32'(axi.wlast), 32'd1);
                chk("wr awlen", 32'(axi.awlen), 32'd0);
                chk("wr awburst", 32'(axi.awburst), 32'd1);
                chk("wr awid", 32'(axi.awid), DATA_ID);
                chk("wr wid", 32'(axi.wid), DATA_ID);
                chk("wr awsize", 32'(axi.awsize), 32'(v.size));
            end
            step();
        end
        axi.awready = 1'b0; axi.wready = 1'b0;
        #1;
        chk("wr D_B awvalid", 32'(axi.awvalid), 32'd0);
        chk("wr D_B wvalid", 32'(axi.wvalid), 32'd0);
        chk("wr D_B addr_ok", 32'(data_addr_ok), 32'd0);
        axi.bvalid = 1'b1; axi.bid = ID_W'(DATA_ID); axi.bresp = v.bresp;
        e.rdata = '0; e.chk_rdata = 1'b0; e.rlast = 1'b0; e.err = (v.bresp != 2'b00);
        data_q.push_back(e);
        step();
        axi.bvalid = 1'b0; axi.bresp = 2'b00;
        #1 chk("wr done addr_ok", 32'(data_addr_ok), 32'd1);
    endtask

    wr_vec_t wr_tab[5];
    int base;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        wr_tab[0] = '{size: 2'd0, addr: 32'h8000_0003, wdata: 32'hAABB_CCDD, aw_dly: 0, w_dly: 2, bresp: 2'b00, exp_wstrb: 4'b1000};
        wr_tab[1] = '{size: 2'd1, addr: 32'h8000_0002, wdata: 32'h1234_5678, aw_dly: 1, w_dly: 0, bresp: 2'b00, exp_wstrb: 4'b1100};
        wr_tab[2] = '{size: 2'd2, addr: 32'h8000_0010, wdata: 32'hDEAD_BEEF, aw_dly: 0, w_dly: 0, bresp: 2'b10, exp_wstrb: 4'b1111};
        wr_tab[3] = '{size: 2'd0, addr: 32'h8000_0001, wdata: 32'h0000_00A5, aw_dly: 3, w_dly: 3, bresp: 2'b00, exp_wstrb: 4'b0010};
        wr_tab[4] = '{size: 2'd3, addr: 32'h8000_0020, wdata: 32'hCAFE_F00D, aw_dly: 2, w_dly: 1, bresp: 2'b11, exp_wstrb: 4'b1111};

        resetn = 1'b0;
        inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0; inst_len = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0; data_len = '0;
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
        axi.bvalid = 1'b0; axi.bid = '0; axi.bresp = 2'b00;

        // reset state
        step(); step();
        chk("rst arvalid", 32'(axi.arvalid), 32'd0);
        chk("rst awvalid", 32'(axi.awvalid), 32'd0);
        chk("rst wvalid", 32'(axi.wvalid), 32'd0);
        chk("rst rready", 32'(axi.rready), 32'd1);
        chk("rst bready", 32'(axi.bready), 32'd1);
        chk("rst inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("rst data_addr_ok", 32'(data_addr_ok), 32'd1);
        resetn = 1'b1;

        // 8-beat inst refill
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2; inst_len = 4'd7;
        #1 chk("i1 addr_ok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        chk("i1 arvalid", 32'(axi.arvalid), 32'd1);
        chk("i1 arid", 32'(axi.arid), INST_ID);
        chk("i1 araddr", axi.araddr, 32'h1FC0_0000);
        chk("i1 arlen", 32'(axi.arlen), 32'd7);
        chk("i1 arburst", 32'(axi.arburst), 32'd1);
        chk("i1 arsize", 32'(axi.arsize), 32'd2);
        chk("i1 busy addr_ok", 32'(inst_addr_ok), 32'd0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        chk("i1 arvalid after hs", 32'(axi.arvalid), 32'd0);
        base = n_inst_ok;
        for (int b = 0; b < 8; b++) begin
            r_set(ID_W'(INST_ID), 32'hC000_0000 + 32'(b), (b == 7), 2'b00);
            step();
        end
        r_clr();
        #1;
        chk("i1 beat count", 32'(n_inst_ok - base), 32'd8);
        chk("i1 idle addr_ok", 32'(inst_addr_ok), 32'd1);

        // data write table
        for (int i = 0; i < 5; i++) do_write(wr_tab[i]);

        // simultaneous inst/data read requests: data wins AR, interleaved R
        inst_req = 1'b1; inst_addr = 32'h0000_1000; inst_size = 2'd2; inst_len = 4'd1;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_2000; data_size = 2'd2; data_len = 4'd1;
        step();
        inst_req = 1'b0; data_req = 1'b0;
        chk("arb arvalid", 32'(axi.arvalid), 32'd1);
        chk("arb first arid", 32'(axi.arid), DATA_ID);
        chk("arb first araddr", axi.araddr, 32'h8000_2000);
        step();
        chk("arb hold arid", 32'(axi.arid), DATA_ID);
        chk("arb hold araddr", axi.araddr, 32'h8000_2000);
        axi.arready = 1'b1;
        step();
        chk("arb second arvalid", 32'(axi.arvalid), 32'd1);
        chk("arb second arid", 32'(axi.arid), INST_ID);
        chk("arb second araddr", axi.araddr, 32'h0000_1000);
        step();
        axi.arready = 1'b0;
        chk("arb arvalid done", 32'(axi.arvalid), 32'd0);
        r_set(ID_W'(DATA_ID), 32'hD000_0000, 1'b0, 2'b00); step();
        r_set(ID_W'(INST_ID), 32'h1000_0000, 1'b0, 2'b00); step();
        r_set(ID_W'(DATA_ID), 32'hD000_0001, 1'b1, 2'b00); step();
        r_set(ID_W'(INST_ID), 32'h1000_0001, 1'b1, 2'b00); step();
        r_clr();
        #1;
        chk("arb inst idle", 32'(inst_addr_ok), 32'd1);
        chk("arb data idle", 32'(data_addr_ok), 32'd1);

        // data read with error during an inst burst
        inst_req = 1'b1; inst_addr = 32'h0000_2000; inst_len = 4'd3;
        step();
        inst_req = 1'b0; axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        r_set(ID_W'(INST_ID), 32'hA000_0000, 1'b0, 2'b00);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h8000_3000; data_len = 4'd0;
        #1 chk("ov data addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        r_set(ID_W'(INST_ID), 32'hA000_0001, 1'b0, 2'b00);
        #1;
        chk("ov arvalid", 32'(axi.arvalid), 32'd1);
        chk("ov arid", 32'(axi.arid), DATA_ID);
        chk("ov arlen", 32'(axi.arlen), 32'd0);
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        r_set(ID_W'(DATA_ID), 32'hEEEE_0000, 1'b1, 2'b10);
        #1 chk("ov data_err", 32'(data_err), 32'd1);
        step();
        r_set(ID_W'(INST_ID), 32'hA000_0002, 1'b0, 2'b00); step();
        r_set(ID_W'(INST_ID), 32'hA000_0003, 1'b1, 2'b00); step();
        r_clr();
        // stray beat for an idle data port is dropped
        axi.rvalid = 1'b1; axi.rid = ID_W'(DATA_ID); axi.rdata = 32'h5555_5555; axi.rlast = 1'b1;
        #1 chk("stray data_data_ok", 32'(data_data_ok), 32'd0);
        step();
        r_clr();
        #1 chk("ov inst idle", 32'(inst_addr_ok), 32'd1);

        // inst last beat and data B in the same cycle
        inst_req = 1'b1; inst_addr = 32'h0000_3000; inst_len = 4'd0;
        data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h8000_4000; data_size = 2'd2; data_wdata = 32'h0BAD_F00D;
        step();
        inst_req = 1'b0; data_req = 1'b0;
        axi.arready = 1'b1; axi.awready = 1'b1; axi.wready = 1'b1;
        step();
        axi.arready = 1'b0; axi.awready = 1'b0; axi.wready = 1'b0;
        r_set(ID_W'(INST_ID), 32'h3333_0000, 1'b1, 2'b00);
        axi.bvalid = 1'b1; axi.bid = ID_W'(DATA_ID); axi.bresp = 2'b00;
        data_q.push_back('{rdata: 32'd0, chk_rdata: 1'b0, rlast: 1'b0, err: 1'b0});
        #1;
        chk("same inst_data_ok", 32'(inst_data_ok), 32'd1);
        chk("same data_data_ok", 32'(data_data_ok), 32'd1);
        step();
        r_clr(); axi.bvalid = 1'b0;
        #1;
        chk("same inst idle", 32'(inst_addr_ok), 32'd1);
        chk("same data idle", 32'(data_addr_ok), 32'd1);

        // reset in the middle of an 8-beat burst
        inst_req = 1'b1; inst_addr = 32'h1FC0_0100; inst_len = 4'd7;
        step();
        inst_req = 1'b0; axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            r_set(ID_W'(INST_ID), 32'hB000_0000 + 32'(b), 1'b0, 2'b00);
            step();
        end
        axi.rvalid = 1'b1; axi.rid = ID_W'(INST_ID); axi.rdata = 32'hB000_0003; axi.rlast = 1'b0;
        resetn = 1'b0;
        #1;
        chk("mrst inst_data_ok", 32'(inst_data_ok), 32'd0);
        chk("mrst arvalid", 32'(axi.arvalid), 32'd0);
        chk("mrst awvalid", 32'(axi.awvalid), 32'd0);
        chk("mrst inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        step();
        resetn = 1'b1;
        #1 chk("stale beat dropped", 32'(inst_data_ok), 32'd0);
        inst_req = 1'b1; inst_addr = 32'h0000_4000; inst_len = 4'd0;
        #1 chk("post-rst addr_ok", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        chk("post-rst arvalid", 32'(axi.arvalid), 32'd1);
        chk("post-rst araddr", axi.araddr, 32'h0000_4000);
        chk("post-rst stale in I_AR", 32'(inst_data_ok), 32'd0);
        r_clr();
        axi.arready = 1'b1;
        step();
        axi.arready = 1'b0;
        r_set(ID_W'(INST_ID), 32'h4444_0000, 1'b1, 2'b00);
        step();
        r_clr();
        step();

        chk("inst queue drained", 32'(inst_q.size()), 32'd0);
        chk("data queue drained", 32'(data_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_axi_burst_bridge.md
# sram_axi_burst_bridge

Parametrised successor to the single-outstanding sram-like/AXI bridge. It connects the CPU's instruction port and data port to one AXI3 master interface. Unlike the previous bridge, it keeps an instruction read and a data transaction in flight at the same time, tagged by distinct AXI IDs. It also supports INCR read bursts for cache-line refills. It sits between the CPU core and the AXI crossbar.

## Interface
Parameters:
- ID_W, 4: AXI ID width.
- INST_ID, 0: ARID used for instruction reads.
- DATA_ID, 1: ARID/AWID/WID used for data accesses. Must differ from INST_ID.
- LEN_W, 4: width of request burst length. Maximum burst is 2^LEN_W beats.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- inst_req, inst_size[1:0], inst_addr[31:0], inst_len[LEN_W-1:0]  in  instruction read request. len = beats-1.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok, inst_rlast, inst_err  out  1  instruction beat valid / final beat / rresp≠0.
- inst_rdata  out  32  instruction read beat.
- data_req, data_wr, data_size[1:0], data_addr[31:0], data_wdata[31:0], data_len[LEN_W-1:0]  in  data request. Writes are single-beat; data_len is ignored when data_wr=1.
- data_addr_ok  out  1  data request accepted.
- data_data_ok, data_rlast, data_err  out  1  data read beat or write response / final / resp≠0.
- data_rdata  out  32  data read beat.
- AXI AR/R/AW/W/B: full AXI3 set. IDs are ID_W bits, araddr/awaddr/rdata/wdata are 32 bits, arlen/awlen are 8 bits, wstrb is 4 bits, and lock/cache/prot are as in the previous bridge.

## Operation
- Inst FSM: I_IDLE → I_AR (request captured) → I_R (ar handshake done) → I_IDLE (beat with rid==INST_ID && rlast).
- Data FSM: D_IDLE → D_AR → D_R → D_IDLE for reads. D_IDLE → D_W → D_B → D_IDLE for writes. D_W leaves only once both aw and w handshakes are done; they may complete in either order or in the same cycle. D_B leaves on bvalid with bid==DATA_ID.
- inst_addr_ok = (inst FSM==I_IDLE). data_addr_ok = (data FSM==D_IDLE). Both are combinational and independent of req. A request is captured on req&&addr_ok into the port's register: addr, size, len, wr, wdata.
- Each port has one transaction outstanding. The two ports run concurrently: an inst burst may overlap a data write or a data read.
- AR arbitration:
  - When both FSMs are in *_AR, data wins.
  - The winner is latched in ar_owner. arvalid and the AR payload stay stable until arready.
  - The loser asserts AR after the winner's handshake.
- AR/AW fields:
  - arid/awid/wid are the owner's ID.
  - arlen = {0, len}. arsize = size.
  - arburst = awburst = 2'b01 (INCR). awlen = 0.
  - wlast = 1.
  - wstrb: size 0 gives 0001<<addr[1:0], size 1 gives 0011<<addr[1:0], otherwise 1111.
- R channel:
  - rready is always 1.
  - Beats are routed by rid. Interleaved beats across the two IDs are legal and are delivered to their own ports in arrival order.
  - *_rdata = rdata. *_rlast = rlast. *_err = (rresp!=0).
  - A beat whose rid matches neither ID, or whose port is not in *_R, is dropped.
- B channel: bready is always 1. data_data_ok pulses on a B beat with bid==DATA_ID in D_B, and data_err = (bresp!=0).
- Ordering: data FSM serialisation guarantees a data read never passes a data write. No ordering is guaranteed between inst and data.

## Timing
- Reset (asynchronous, any state):
  - FSMs go to idle and ar_owner clears.
  - arvalid, awvalid and wvalid go to 0.
  - All *_data_ok, *_rlast and *_err outputs go to 0.
  - rready = bready = 1, and both addr_ok outputs = 1.
  - In-flight AXI transactions are abandoned, and late responses after reset are dropped by the rules above.
- Accept in cycle N → arvalid/awvalid/wvalid high in N+1 at the earliest. Read data_ok is combinational from rvalid, giving 0 added latency.
- Port returns to idle the cycle after its last beat/B. addr_ok is high at N+1; there is no back-to-back accept in the completion cycle.
- Simultaneous arready for the owner and a new inst request being accepted: the new request enters I_AR and arbitrates the following cycle.
- The R beat completing the inst burst and the data B completing in the same cycle: both data_ok pulse in that cycle.
- A len=maximum burst of 2^LEN_W beats is counted only by rlast. No internal beat counter is required, but one may be added for an assertion check.

## Test plan
- Inst read, len=7, addr 0x1FC0_0000, with slave returning 8 beats, 1 per cycle → 8 inst_data_ok pulses, inst_rlast on beat 8. arlen=7, arburst=01, arid=INST_ID.
- Data sb (size 0) to 0x8000_0003, wdata 0xAABBCCDD, with slave awready 2 cycles before wready → wstrb=1000 and a single data_data_ok on B, data_err=0.
- Inst and data reads requested in the same cycle → data AR issued first. Inst AR is held until data arready. Slave returns interleaved rid 1/0/1/0 beats → each beat appears on the correct port.
- Data read issued while the inst burst is still in I_R, with bresp/rresp=2'b10 on the data side → data_err=1 with data_data_ok, and the inst burst is unaffected.
- resetn low mid-burst (beat 3 of 8), then released and a stale rvalid arrives → all valids 0, no data_ok, and a new request is accepted the cycle after release.
